irrigation_sequencer: RTL and testbench

- Downstream stage of the irrigation pre-requisite check; consumes its irrigation_mode qualifier and the shared sensor error flag.
- Runs one timed watering cycle per request: open main valve, let line pressurise, drive the dripper or sprinkler, hold a minimum run, then drain, close and cool down.
- Guarantees a bounded run length and clean shutdown on error.

---
 rtl/irrigation_sequencer.sv | 125 ++++++++++++
 tb/tb_irrigation_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/irrigation_sequencer.sv
// irrigation_sequencer: timed valve/actuator sequencer for one watering run per request.
// Rev 1.0 - initial release.
`default_nettype none

module irrigation_sequencer #(
  parameter int VALVE_DELAY = 4,
  parameter int MIN_RUN     = 8,
  parameter int MAX_RUN     = 64,
  parameter int COOLDOWN    = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic irrigation_mode,
  input  logic error,
  input  logic use_sprinkler,
  output logic valve_open,
  output logic dripper_on,
  output logic sprinkler_on,
  output logic busy,
  output logic run_done,
  output logic timeout,
  output logic fault
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OPEN     = 3'd1,
    ST_IRRIGATE = 3'd2,
    ST_CLOSE    = 3'd3,
    ST_COOL     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] VALVE_LAST = CNT_W'(VALVE_DELAY - 1);
  localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_RUN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_RUN - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      sel      <= 1'b0;
      run_done <= 1'b0;
      timeout  <= 1'b0;
      fault    <= 1'b0;
    end else begin
      run_done <= 1'b0;
      timeout  <= 1'b0;
      fault    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (irrigation_mode && !error) begin
            sel   <= use_sprinkler;
            cnt   <= '0;
            state <= ST_OPEN;
          end
        end
        ST_OPEN: begin
          if (error) begin
            fault <= 1'b1;
            cnt   <= '0;
            state <= ST_CLOSE;
          end else if (cnt == VALVE_LAST) begin
            cnt   <= '0;
            state <= ST_IRRIGATE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IRRIGATE: begin
          // Exit priority: error, then MAX_RUN, then the normal end of request.
          if (error) begin
            fault <= 1'b1;
            cnt   <= '0;
            state <= ST_CLOSE;
          end else if (cnt == MAX_LAST) begin
            timeout <= 1'b1;
            cnt     <= '0;
            state   <= ST_CLOSE;
          end else if (cnt >= MIN_LAST && !irrigation_mode) begin
            run_done <= 1'b1;
            cnt      <= '0;
            state    <= ST_CLOSE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CLOSE: begin
          if (cnt == VALVE_LAST) begin
            cnt   <= '0;
            state <= ST_COOL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_COOL: begin
          if (cnt == COOL_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Decoded straight from registered state so an async reset drops everything at once.
  assign valve_open   = (state == ST_OPEN) || (state == ST_IRRIGATE) || (state == ST_CLOSE);
  assign dripper_on   = (state == ST_IRRIGATE) && !sel;
  assign sprinkler_on = (state == ST_IRRIGATE) && sel;
  assign busy         = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_irrigation_sequencer.sv
// tb_irrigation_sequencer: table-driven scoreboard bench for irrigation_sequencer.
// Rev 1.0 - initial release.
`default_nettype none

module tb_irrigation_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irrigation_mode = 1'b0;
  logic error = 1'b0;
  logic use_sprinkler = 1'b0;
  logic valve_open, dripper_on, sprinkler_on, busy, run_done, timeout, fault;

  irrigation_sequencer #(
    .VALVE_DELAY(4), .MIN_RUN(8), .MAX_RUN(64), .COOLDOWN(16), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .irrigation_mode(irrigation_mode), .error(error),
    .use_sprinkler(use_sprinkler), .valve_open(valve_open), .dripper_on(dripper_on),
    .sprinkler_on(sprinkler_on), .busy(busy), .run_done(run_done), .timeout(timeout),
    .fault(fault)
  );

  always #5 clk = ~clk;

  // Output vector order: valve, dripper, sprinkler, busy, run_done, timeout, fault
  localparam logic [6:0] ID  = 7'b0000000;
  localparam logic [6:0] OC  = 7'b1001000;  // OPEN or CLOSE
  localparam logic [6:0] DR  = 7'b1101000;
  localparam logic [6:0] SP  = 7'b1011000;
  localparam logic [6:0] CRD = 7'b1001100;
  localparam logic [6:0] CTO = 7'b1001010;
  localparam logic [6:0] CF  = 7'b1001001;
  localparam logic [6:0] CL  = 7'b0001000;

  typedef struct {
    logic       mode;
    logic       err;
    logic       spr;
    int         n;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t       tbl[$];
  logic [6:0] sb_q[$];
  int         checks = 0;
  int         errors = 0;

  wire [6:0] outs = {valve_open, dripper_on, sprinkler_on, busy, run_done, timeout, fault};

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic m, input logic e, input logic s, input int n,
                     input logic [6:0] x, input string name);
    vec_t v;
    v.mode = m; v.err = e; v.spr = s; v.n = n; v.exp = x; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    logic [6:0] exp;
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      irrigation_mode = v.mode;
      error           = v.err;
      use_sprinkler   = v.spr;
      sb_q.push_back(v.exp);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s: scoreboard empty", v.name);
      end else begin
        exp = sb_q.pop_front();
        check($sformatf("%s[%0d]", v.name, i), outs, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset / idle
    add(0, 0, 0, 20, ID, "idle");
    // Normal dripper run, request dropped early
    add(1, 0, 0, 4, OC, "drip_open");
    add(1, 0, 0, 3, DR, "drip_on_hi");
    add(0, 0, 0, 5, DR, "drip_on_lo");
    add(0, 0, 0, 1, CRD, "drip_done");
    add(0, 0, 0, 3, OC, "drip_close");
    add(0, 0, 0, 16, CL, "drip_cool");
    add(0, 0, 0, 1, ID, "drip_idle");
    // Sprinkler timeout, automatic restart, select toggled mid-run
    add(1, 0, 1, 4, OC, "spr_open");
    add(1, 0, 1, 64, SP, "spr_on");
    add(1, 0, 1, 1, CTO, "spr_timeout");
    add(1, 0, 1, 3, OC, "spr_close");
    add(1, 0, 1, 16, CL, "spr_cool");
    add(1, 0, 1, 1, ID, "spr_idle");
    add(1, 0, 1, 4, OC, "re_open");
    add(0, 0, 0, 8, SP, "re_latched");
    add(0, 0, 0, 1, CRD, "re_done");
    add(0, 0, 0, 3, OC, "re_close");
    add(0, 0, 0, 16, CL, "re_cool");
    add(0, 0, 0, 1, ID, "re_idle");
    // Error abort at IRRIGATE counter=3
    add(1, 0, 0, 4, OC, "eir_open");
    add(1, 0, 0, 4, DR, "eir_on");
    add(1, 1, 0, 1, CF, "eir_fault");
    add(0, 0, 0, 3, OC, "eir_close");
    add(0, 0, 0, 16, CL, "eir_cool");
    add(0, 0, 0, 1, ID, "eir_idle");
    // Error abort in OPEN; error ignored while draining
    add(1, 0, 1, 1, OC, "eop_open");
    add(1, 1, 1, 1, CF, "eop_fault");
    add(0, 1, 0, 3, OC, "eop_close");
    add(0, 0, 0, 16, CL, "eop_cool");
    add(0, 0, 0, 1, ID, "eop_idle");
    // Start blocked by error
    add(1, 1, 0, 5, ID, "blocked");
    // Timeout and normal end coincide: timeout only
    add(1, 0, 0, 4, OC, "coin_open");
    add(1, 0, 0, 64, DR, "coin_on");
    add(0, 0, 0, 1, CTO, "coin_timeout");
    add(0, 0, 0, 3, OC, "coin_close");
    add(0, 0, 0, 16, CL, "coin_cool");
    add(0, 0, 0, 1, ID, "coin_idle");

    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", outs, ID);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);

    // Async reset between edges during IRRIGATE
    begin
      vec_t v;
      v.mode = 1; v.err = 0; v.spr = 1; v.n = 4; v.exp = OC; v.name = "ar_open";
      apply(v);
      v.n = 3; v.exp = SP; v.name = "ar_on";
      apply(v);
    end
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_now", outs, ID);
    @(negedge clk);
    irrigation_mode = 1'b0;
    @(posedge clk);
    #1;
    check("async_reset_held", outs, ID);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("after_release", outs, ID);
    begin
      vec_t v;
      v.mode = 1; v.err = 0; v.spr = 0; v.n = 1; v.exp = OC; v.name = "post_rst_start";
      apply(v);
    end
    check("scoreboard_drained", {6'd0, sb_q.size() == 0}, 7'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
